cmos_gate_sweep_ctrl: RTL and testbench
=======================================

# cmos_gate_sweep_ctrl

Sequencer that exhaustively exercises the team's 4-input complex AOI CMOS gate cell, where Y = ~(D | (A & (B | C))). It drives all 16 input vectors in order and waits a programmable settle time per vector. It samples the gate output, compares it against the golden function, and reports pass/fail, a mismatch count and the first failing vector. It sits beside the switch-level gate instance in the characterisation bench and owns the gate's A/B/C/D inputs while busy.

## Interface
Parameters:
- SETTLE_CYCLES, 2, cycles between applying a vector and sampling Y (legal range 1..15)
- STOP_ON_FAIL, 0, 1 = end the run at the first mismatch

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to begin a sweep; accepted only in IDLE
- abort  in  1  terminate the current sweep
- drv_a, drv_b, drv_c, drv_d  out  1 each  registered gate inputs
- y_in  in  1  gate output Y
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep completion
- pass  out  1  held result: done-run with err_count == 0
- err_count  out  5  mismatches in the last run (0..16)
- first_fail_valid  out  1  at least one mismatch recorded
- first_fail_vec  out  4  {A,B,C,D} of the first mismatch

## Operation
- Vector index vec counts 0..15; drive mapping {drv_a,drv_b,drv_c,drv_d} = vec[3:0].
- Expected Y = ~(vec[0] | (vec[3] & (vec[2] | vec[1]))).
- FSM states and transitions:
  - IDLE -> SETTLE on start & ~abort.
  - SETTLE: counts down SETTLE_CYCLES, then -> SAMPLE.
  - SAMPLE: compares y_in to expected, updates results, and applies the next vector. Goes -> SETTLE if vec < 15, else -> DONE. With STOP_ON_FAIL = 1, a mismatch goes -> DONE.
  - DONE -> IDLE unconditionally after one cycle.
- Mismatch handling: err_count increments. On the first mismatch, first_fail_vec is captured and first_fail_valid is set.
- Start handling: start clears err_count, first_fail_*, and pass.
- Abort: from SETTLE or SAMPLE, abort goes -> IDLE next edge. No done pulse, pass stays 0, partial err_count is retained, and drives return to 0.
- Simultaneous or ignored inputs:
  - start and abort in the same cycle in IDLE: abort wins and start is ignored.
  - start while busy: ignored.
  - abort in IDLE or DONE: no effect.

## Timing
- Reset values:
  - all drv_* = 0
  - busy = 0, done = 0, pass = 0
  - err_count = 0
  - first_fail_valid = 0, first_fail_vec = 0
  - state IDLE
- Sweep start: start is sampled at edge E0. At E0 busy rises and drives = vector 0.
- Per-vector window: SETTLE_CYCLES + 1 cycles. Vector k is applied at edge E0 + k·W. y_in is sampled at edge E0 + (k+1)·W, the same edge that applies vector k+1.
- End of run:
  - Last sample at E0 + 16·W.
  - At that edge busy falls, done = 1 for exactly one cycle, pass and err_count become valid, and drives return to 0.
- Latency: a full run takes 16·W cycles from start acceptance to done.
- Result hold: results are held from done until the next accepted start.
- Reset mid-run: all outputs take their reset values immediately. The next start performs a full sweep.

## Structure
- Package cmos_sweep_pkg contains:
  - the state enum (IDLE, SETTLE, SAMPLE, DONE)
  - VEC_W = 4 and NUM_VEC = 16
  - the function expected_y(vec) implementing the golden equation
- One sub-module, sweep_settle_timer: a loadable down-counter with a zero flag, loaded at each vector apply.
- The FSM, vector counter and result registers stay in the top module.

## Test plan
- Correct gate instance, SETTLE_CYCLES = 2, start pulse:
  - busy high for 48 cycles and done pulses once at edge E0+48
  - err_count = 0, pass = 1, first_fail_valid = 0
- y_in tied 0:
  - err_count = 5, pass = 0
  - first_fail_vec = 4'b0000
- y_in tied 1:
  - err_count = 11
  - first_fail_vec = 4'b0001
- STOP_ON_FAIL = 1 with y_in tied 1:
  - done at E0+6
  - err_count = 1, first_fail_vec = 4'b0001
- abort asserted at E0+10:
  - busy low and drives 0 at the next edge
  - no done pulse
  - a start pulse during busy earlier in the run was ignored
- rst_n pulsed low at E0+20:
  - all outputs reset asynchronously
  - a new start completes a full 48-cycle sweep with pass = 1

Source files
------------

// File: rtl/cmos_sweep_pkg.sv
// cmos_sweep_pkg: shared state type, sizes and golden AOI function for the gate sweep
package cmos_sweep_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} sweep_state_e;
  localparam int VEC_W = 4;
  localparam int NUM_VEC = 16;
  function automatic logic expected_y(input logic [VEC_W-1:0] vec);
    return ~(vec[0] | (vec[3] & (vec[2] | vec[1])));
  endfunction
endpackage

// File: rtl/sweep_settle_timer.sv
// sweep_settle_timer: loadable down-counter with zero flag timing each vector's settle window
module sweep_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       zero
);
  logic [3:0] cnt;
  assign zero = cnt == 4'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= 4'd0;
    else cnt <= load ? load_val : (en && !zero) ? cnt - 4'd1 : cnt;
endmodule

// File: rtl/cmos_gate_sweep_ctrl.sv
// cmos_gate_sweep_ctrl: walks all 16 AOI gate input vectors, samples Y after a settle time
// and reports pass, mismatch count and first failing vector
module cmos_gate_sweep_ctrl
  import cmos_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter bit STOP_ON_FAIL  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       drv_a,
  output logic       drv_b,
  output logic       drv_c,
  output logic       drv_d,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       first_fail_valid,
  output logic [3:0] first_fail_vec
);
  sweep_state_e state;
  logic [VEC_W-1:0] vec, drv;
  logic tmr_load, tmr_zero, mism, last;
  logic [4:0] err_next;
  assign {drv_a, drv_b, drv_c, drv_d} = drv;
  assign mism = y_in != expected_y(vec);
  assign err_next = err_count + 5'(mism);
  assign last = (vec == VEC_W'(NUM_VEC - 1)) || (STOP_ON_FAIL && mism);
  // timer restarts whenever a new vector is driven onto the gate
  assign tmr_load = !abort && ((state == IDLE && start) || (state == SAMPLE && !last));
  sweep_settle_timer u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .load_val(4'(SETTLE_CYCLES - 1)),
    .en      (state == SETTLE),
    .zero    (tmr_zero)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      vec              <= '0;
      drv              <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && !abort) begin
          state            <= SETTLE;
          busy             <= 1'b1;
          vec              <= '0;
          drv              <= '0;
          pass             <= 1'b0;
          err_count        <= '0;
          first_fail_valid <= 1'b0;
          first_fail_vec   <= '0;
        end
        SETTLE: if (abort) begin
          state <= IDLE;
          busy  <= 1'b0;
          drv   <= '0;
        end else if (tmr_zero) state <= SAMPLE;
        SAMPLE: if (abort) begin
          state <= IDLE;
          busy  <= 1'b0;
          drv   <= '0;
        end else begin
          err_count <= err_next;
          if (mism && !first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_vec   <= vec;
          end
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            drv   <= '0;
            pass  <= err_next == 5'd0;
          end else begin
            state <= SETTLE;
            vec   <= vec + 1'b1;
            drv   <= vec + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmos_gate_sweep_ctrl.sv
// tb_cmos_gate_sweep_ctrl: drives a modelled AOI gate (optionally faulty) and checks sweep results
module tb_cmos_gate_sweep_ctrl;
  localparam int W = 3;
  localparam logic [15:0] GOLD = 16'h0155;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, start_s = 1'b0;
  logic [1:0] ymode = 2'd0;
  logic [15:0] fmask = 16'h0;
  logic sel = 1'b0;
  logic drv_a, drv_b, drv_c, drv_d, busy, done, pass, ffv, y_in;
  logic [4:0] err_count;
  logic [3:0] ffvec;
  logic sa, sb, sc, sd, busy_s, done_s, pass_s, ffv_s, y_s;
  logic [4:0] err_s;
  logic [3:0] ffvec_s;
  logic [3:0] idx, idx_s, o_drv, o_ffvec;
  logic o_busy, o_done, o_pass, o_ffv;
  logic [4:0] o_err;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign idx = {drv_a, drv_b, drv_c, drv_d};
  assign idx_s = {sa, sb, sc, sd};
  assign y_in = ymode == 2'd1 ? 1'b0 : ymode == 2'd2 ? 1'b1 : GOLD[idx] ^ fmask[idx];
  assign y_s = ymode == 2'd1 ? 1'b0 : ymode == 2'd2 ? 1'b1 : GOLD[idx_s] ^ fmask[idx_s];
  assign o_drv = sel ? idx_s : idx;
  assign o_busy = sel ? busy_s : busy;
  assign o_done = sel ? done_s : done;
  assign o_pass = sel ? pass_s : pass;
  assign o_ffv = sel ? ffv_s : ffv;
  assign o_err = sel ? err_s : err_count;
  assign o_ffvec = sel ? ffvec_s : ffvec;
  cmos_gate_sweep_ctrl #(.SETTLE_CYCLES(2), .STOP_ON_FAIL(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .drv_a(drv_a), .drv_b(drv_b), .drv_c(drv_c), .drv_d(drv_d), .y_in(y_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_valid(ffv), .first_fail_vec(ffvec)
  );
  cmos_gate_sweep_ctrl #(.SETTLE_CYCLES(2), .STOP_ON_FAIL(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .abort(1'b0),
    .drv_a(sa), .drv_b(sb), .drv_c(sc), .drv_d(sd), .y_in(y_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s),
    .first_fail_valid(ffv_s), .first_fail_vec(ffvec_s)
  );
  // reference: what the gate under the current fault setting returns for vector k
  function automatic logic model_y(input int k);
    logic [15:0] g, m;
    g = GOLD;
    m = fmask;
    return ymode == 2'd1 ? 1'b0 : ymode == 2'd2 ? 1'b1 : g[k] ^ m[k];
  endfunction
  task automatic ref_results(input bit stop, output int n_err, output int first, output int done_at);
    logic [15:0] g;
    g = GOLD;
    n_err = 0;
    first = -1;
    done_at = 16 * W;
    for (int k = 0; k < 16; k++)
      if (model_y(k) != g[k]) begin
        n_err++;
        if (first < 0) first = k;
        if (stop) begin
          done_at = (k + 1) * W;
          break;
        end
      end
  endtask
  task automatic run_sweep(input bit s, output int busy_n, output int done_at, output int done_n);
    int lim;
    sel = s;
    busy_n = 0;
    done_at = -1;
    done_n = 0;
    lim = 200;
    @(negedge clk);
    if (s) start_s = 1'b1; else start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start_s = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      checks++;
      if (o_drv !== (o_busy ? 4'(i / W) : 4'd0)) begin
        errors++;
        $display("FAIL drive_seq cycle %0d: got %h want %h", i, o_drv, o_busy ? 4'(i / W) : 4'd0);
      end
      if (o_busy) busy_n++;
      if (o_done) begin
        done_n++;
        if (done_at < 0) begin
          done_at = i;
          lim = i + 4;
        end
      end
    end
  endtask
  task automatic check_result(input string name, input bit stop, input int busy_n, input int done_at, input int done_n);
    int n_err, first, exp_done;
    ref_results(stop, n_err, first, exp_done);
    checks++;
    if (done_at != exp_done || done_n != 1) begin
      errors++;
      $display("FAIL %s done_timing: at %0d x%0d want at %0d x1", name, done_at, done_n, exp_done);
    end
    checks++;
    if (busy_n != exp_done) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_n, exp_done);
    end
    checks++;
    if (o_err !== 5'(n_err)) begin
      errors++;
      $display("FAIL %s err_count: got %0d want %0d", name, o_err, n_err);
    end
    checks++;
    if (o_pass !== (n_err == 0)) begin
      errors++;
      $display("FAIL %s pass: got %b want %b", name, o_pass, n_err == 0);
    end
    checks++;
    if (o_ffv !== (first >= 0) || (first >= 0 && o_ffvec !== 4'(first))) begin
      errors++;
      $display("FAIL %s first_fail: got %b/%h want %b/%h", name, o_ffv, o_ffvec, first >= 0, 4'(first));
    end
  endtask
  task automatic test_reset;
    checks++;
    if ({drv_a, drv_b, drv_c, drv_d, busy, done, pass, err_count, ffv, ffvec} !== 18'd0) begin
      errors++;
      $display("FAIL reset_values: drv=%h busy=%b done=%b pass=%b err=%0d ffv=%b ffvec=%h",
               idx, busy, done, pass, err_count, ffv, ffvec);
    end
  endtask
  task automatic test_golden;
    int b, d, n;
    ymode = 2'd0;
    fmask = 16'h0;
    run_sweep(1'b0, b, d, n);
    check_result("golden", 1'b0, b, d, n);
    repeat (5) @(negedge clk);
    checks++;
    if (pass !== 1'b1 || err_count !== 5'd0) begin
      errors++;
      $display("FAIL result_hold: pass=%b err=%0d want 1/0", pass, err_count);
    end
  endtask
  task automatic test_tied(input logic [1:0] m, input string name);
    int b, d, n;
    ymode = m;
    run_sweep(1'b0, b, d, n);
    check_result(name, 1'b0, b, d, n);
  endtask
  task automatic test_random_faults;
    int b, d, n;
    ymode = 2'd0;
    for (int r = 0; r < 4; r++) begin
      fmask = 16'($urandom & $urandom);
      run_sweep(1'b0, b, d, n);
      check_result("random", 1'b0, b, d, n);
    end
    fmask = 16'h0;
  endtask
  task automatic test_stop_on_fail;
    int b, d, n;
    ymode = 2'd2;
    run_sweep(1'b1, b, d, n);
    check_result("stop_tie1", 1'b1, b, d, n);
    ymode = 2'd0;
    fmask = 16'(1 << $urandom_range(0, 15)) | 16'h8000;
    run_sweep(1'b1, b, d, n);
    check_result("stop_random", 1'b1, b, d, n);
    fmask = 16'h0;
    sel = 1'b0;
  endtask
  task automatic test_abort;
    int dn;
    ymode = 2'd1;
    dn = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = i == 4;
      abort = i == 10;
      @(posedge clk);
      #1;
      if (i == 7) begin
        checks++;
        if (idx !== 4'd2 || !busy) begin
          errors++;
          $display("FAIL start_while_busy: drv=%h busy=%b want 2/1", idx, busy);
        end
      end
    end
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || idx !== 4'd0) begin
      errors++;
      $display("FAIL abort_stop: busy=%b drv=%h want 0/0", busy, idx);
    end
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_idle: busy=%b want 0", busy);
    end
    repeat (60) begin
      @(negedge clk);
      if (done) dn++;
    end
    checks++;
    if (dn != 0 || pass !== 1'b0 || err_count !== 5'd2 || ffv !== 1'b1 || ffvec !== 4'd0) begin
      errors++;
      $display("FAIL abort_results: dones=%0d pass=%b err=%0d ffv=%b ffvec=%h want 0/0/2/1/0",
               dn, pass, err_count, ffv, ffvec);
    end
  endtask
  task automatic test_reset_mid_run;
    int b, d, n;
    ymode = 2'd1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    ymode = 2'd0;
    run_sweep(1'b0, b, d, n);
    check_result("after_reset", 1'b0, b, d, n);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_golden;
    test_tied(2'd1, "tie0");
    test_tied(2'd2, "tie1");
    test_random_faults;
    test_stop_on_fail;
    test_abort;
    test_reset_mid_run;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
